stack_ctrl: RTL and testbench

Sequencer for the CPU scratch (data) stack. It caches the top two elements in registers (tos, nos) and spills deeper elements to an external single-port, registered-read stack RAM. It accepts one PUSH/POP/REPLACE command at a time over a valid/ready handshake, and it tracks depth, overflow and underflow. It replaces the ad-hoc push and pop phase sequencing in the CPU core.

---
 rtl/stack_pkg.sv | 15 +
 rtl/stack_ctrl.sv | 93 +++++++++
 tb/tb_stack_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: command and state encodings shared by the stack controller.
package stack_pkg;
  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD1  = 2'd2,
    RD2  = 2'd3
  } state_t;
endpackage

// File: rtl/stack_ctrl.sv
// stack_ctrl: data stack sequencer caching tos/nos and spilling deeper words to a registered-read RAM.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int MAX_DEPTH = (1 << AW) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic          cmd_ready,
  input  logic          clr_err,
  output logic [DW-1:0] tos,
  output logic [DW-1:0] nos,
  output logic [AW+1:0] depth,
  output logic          overflow,
  output logic          underflow,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wen,
  input  logic [DW-1:0] ram_rdata
);
  localparam logic [AW+1:0] FULL = (AW+2)'(MAX_DEPTH);
  localparam logic [AW+1:0] ONE  = (AW+2)'(1);
  localparam logic [AW+1:0] TWO  = (AW+2)'(2);
  state_t state;
  logic [AW:0] sp, sp_dec;
  assign cmd_ready = state == IDLE;
  assign sp_dec = sp - 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tos       <= '0;
      nos       <= '0;
      depth     <= '0;
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wen   <= 1'b0;
    end else begin
      ram_wen <= 1'b0;
      // clear first so an error raised this same cycle wins
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      case (state)
        IDLE: if (cmd_valid) begin
          case (op_t'(cmd_op))
            OP_NOP: ;
            OP_PUSH: if (depth == FULL) overflow <= 1'b1;
            else begin
              tos   <= cmd_data;
              nos   <= tos;
              depth <= depth + ONE;
              if (depth >= TWO) begin
                ram_addr  <= sp[AW-1:0];
                ram_wdata <= nos;
                ram_wen   <= 1'b1;
                sp        <= sp + 1'b1;
                state     <= WR;
              end
            end
            OP_POP: if (depth == '0) underflow <= 1'b1;
            else begin
              tos   <= nos;
              depth <= depth - ONE;
              if (depth <= TWO) nos <= '0;
              else begin
                ram_addr <= sp_dec[AW-1:0];
                sp       <= sp_dec;
                state    <= RD1;
              end
            end
            OP_REPLACE: tos <= cmd_data;
          endcase
        end
        WR:  state <= IDLE;
        RD1: state <= RD2;
        RD2: begin
          nos   <= ram_rdata;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: scoreboard bench for stack_ctrl with a behavioural registered-read RAM.
module tb_stack_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MAXD = (1 << AW) + 2;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_ready;
  logic          clr_err = 1'b0;
  logic [DW-1:0] tos, nos;
  logic [AW+1:0] depth;
  logic          overflow, underflow;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wen;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] mem [1 << AW];

  stack_ctrl #(.AW(AW), .DW(DW), .MAX_DEPTH(MAXD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .clr_err(clr_err), .tos(tos), .nos(nos), .depth(depth),
    .overflow(overflow), .underflow(underflow), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wen(ram_wen), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic [DW-1:0] tos, nos, wdata;
    int            depth, busy;
    logic          ovf, unf, wen, fill;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] spill[$];
  logic [DW-1:0] m_tos, m_nos;
  int            m_depth;
  logic          m_ovf, m_unf;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tos = '0; m_nos = '0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    spill.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] d, input logic clr = 1'b0);
    exp_t e;
    int   busy, w;
    e.wen = 1'b0; e.fill = 1'b0; e.addr = '0; e.wdata = '0; e.busy = 1;
    if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    case (op)
      2'd1: if (m_depth == MAXD) m_ovf = 1'b1;
      else begin
        if (m_depth >= 2) begin
          e.wen = 1'b1; e.addr = AW'(spill.size()); e.wdata = m_nos; e.busy = 2;
          spill.push_back(m_nos);
        end
        m_nos = m_tos; m_tos = d; m_depth++;
      end
      2'd2: if (m_depth == 0) m_unf = 1'b1;
      else begin
        m_tos = m_nos;
        if (m_depth > 2) begin
          e.fill = 1'b1; e.addr = AW'(spill.size() - 1); e.busy = 3;
          m_nos = spill.pop_back();
        end else m_nos = '0;
        m_depth--;
      end
      2'd3: m_tos = d;
      default: ;
    endcase
    e.tos = m_tos; e.nos = m_nos; e.depth = m_depth; e.ovf = m_ovf; e.unf = m_unf;
    sb.push_back(e);
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    chk("ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; clr_err = clr;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_op = 2'd0; clr_err = 1'b0;
    e = sb.pop_front();
    chk("ram_wen", 64'(ram_wen), 64'(e.wen));
    if (e.wen) begin
      chk("spill_addr", 64'(ram_addr), 64'(e.addr));
      chk("spill_data", 64'(ram_wdata), 64'(e.wdata));
    end
    if (e.fill) chk("fill_addr", 64'(ram_addr), 64'(e.addr));
    busy = 1;
    while (!cmd_ready && busy < 10) begin @(posedge clk); #1 busy++; end
    chk("busy", 64'(busy), 64'(e.busy));
    chk("wen_end", 64'(ram_wen), 64'd0);
    chk("tos", 64'(tos), 64'(e.tos));
    chk("nos", 64'(nos), 64'(e.nos));
    chk("depth", 64'(depth), 64'(e.depth));
    chk("overflow", 64'(overflow), 64'(e.ovf));
    chk("underflow", 64'(underflow), 64'(e.unf));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk("rst_tos", 64'(tos), 64'd0);
    chk("rst_nos", 64'(nos), 64'd0);
    chk("rst_depth", 64'(depth), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_unf", 64'(underflow), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_wen", 64'(ram_wen), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    chk("rst_wdata", 64'(ram_wdata), 64'd0);
    do_cmd(2'd1, 32'h11);
    do_cmd(2'd1, 32'h22);
    do_cmd(2'd1, 32'h33);
    do_cmd(2'd2, '0);
    while (m_depth < MAXD) do_cmd(2'd1, 32'h1000 + 32'(m_depth));
    do_cmd(2'd1, 32'hAA);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    m_ovf = 1'b0;
    chk("clr_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    do_cmd(2'd1, 32'hBB, 1'b1);
    do_cmd(2'd0, '0, 1'b1);
    while (m_depth > 0) do_cmd(2'd2, '0);
    do_cmd(2'd2, '0);
    do_cmd(2'd1, 32'h1);
    do_cmd(2'd3, 32'h5);
    do_cmd(2'd0, '0, 1'b1);
    do_cmd(2'd2, '0);
    do_cmd(2'd3, 32'h77);
    do_cmd(2'd2, '0);
    do_reset();
    do_cmd(2'd1, 32'h1);
    do_cmd(2'd1, 32'h2);
    do_cmd(2'd1, 32'h3);
    cmd_valid = 1'b1; cmd_op = 2'd2;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_op = 2'd0;
    chk("rd1_busy", 64'(cmd_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("mid_depth", 64'(depth), 64'd0);
    chk("mid_ready", 64'(cmd_ready), 64'd1);
    chk("mid_wen", 64'(ram_wen), 64'd0);
    chk("mid_tos", 64'(tos), 64'd0);
    chk("mid_nos", 64'(nos), 64'd0);
    @(negedge clk);
    do_cmd(2'd1, 32'h99);
    do_cmd(2'd1, 32'hA);
    do_cmd(2'd1, 32'hB);
    do_cmd(2'd2, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
